// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator key sequencer: keypad key codes,
// ALU operation codes, sequencer state encodings and key classification
// helpers.
// ---------------------------------------------------------------------------
package calc_pkg;

   // Non-digit key codes coming from the 4x4 keypad controller
   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_DIV = 4'hD;
   localparam logic [3:0] KEY_EQ  = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;

   // Operation code presented to the arithmetic unit
   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   // Sequencer state encodings (also driven onto state_o)
   localparam logic [2:0] ST_ENTER_A = 3'd0;
   localparam logic [2:0] ST_OP_WAIT = 3'd1;
   localparam logic [2:0] ST_ENTER_B = 3'd2;
   localparam logic [2:0] ST_REQ     = 3'd3;
   localparam logic [2:0] ST_RESULT  = 3'd4;

   function automatic logic is_digit(input logic [3:0] tecla);
      return (tecla <= 4'd9);
   endfunction

   function automatic logic is_op(input logic [3:0] tecla);
      return (tecla >= KEY_ADD) && (tecla <= KEY_DIV);
   endfunction

   function automatic logic [1:0] key_to_op(input logic [3:0] tecla);
      op_e op_v;
      case (tecla)
         KEY_ADD: op_v = OP_ADD;
         KEY_SUB: op_v = OP_SUB;
         KEY_MUL: op_v = OP_MUL;
         KEY_DIV: op_v = OP_DIV;
         default: op_v = OP_ADD;
      endcase
      return op_v;
   endfunction

endpackage

// File: rtl/key_event_detect.sv
// ---------------------------------------------------------------------------
// key_event_detect
// Turns the debounced keypad "ready" level into a single-cycle key event.
// ready is registered twice; the event fires on the cycle after ready is
// first seen high, when the keypad's registered tecla has settled, so the
// key code is taken from tecla on that same cycle. A held key gives one
// event; ready must drop for at least one cycle before the next.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   tecla  [3:0]   key code from keypad controller
//   ready          high while a key is held
//   key_evt        one-cycle pulse per key press
//   key_code [3:0] key code valid while key_evt is high
// ---------------------------------------------------------------------------
module key_event_detect (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] tecla,
   input  logic       ready,
   output logic       key_evt,
   output logic [3:0] key_code
);

   logic ready_r1_r;
   logic ready_r2_r;

   // Two-stage ready pipeline used for rising-edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_r1_r <= 1'b0;
         ready_r2_r <= 1'b0;
      end else begin
         ready_r1_r <= ready;
         ready_r2_r <= ready_r1_r;
      end
   end

   assign key_evt  = ready_r1_r & ~ready_r2_r;
   assign key_code = tecla;

endmodule

// File: rtl/calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// calc_key_sequencer
// Assembles keypad events into calculator transactions: BCD operands A and
// B, an operator, a held request to the ALU and a latched result for the
// display. Operator keys pressed while entering B chain a new operation
// onto the result.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   tecla[3:0], ready   keypad controller output
//   calc_ack            ALU done, calc_result valid this cycle
//   calc_result         BCD result from ALU
//   operand_a/b         BCD operands to ALU
//   op_code[1:0]        00 add, 01 sub, 10 mul, 11 div
//   calc_req            held high until calc_ack
//   disp_value          A, B or result depending on state
//   state_o[2:0]        current state
// ---------------------------------------------------------------------------
module calc_key_sequencer
   import calc_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [3:0]        tecla,
   input  logic              ready,
   input  logic              calc_ack,
   input  logic [4*NDIG-1:0] calc_result,
   output logic [4*NDIG-1:0] operand_a,
   output logic [4*NDIG-1:0] operand_b,
   output logic [1:0]        op_code,
   output logic              calc_req,
   output logic [4*NDIG-1:0] disp_value,
   output logic [2:0]        state_o
);

   localparam int W  = 4 * NDIG;
   localparam int CW = $clog2(NDIG + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          key_evt_s;
   logic [3:0]    key_code_s;

   logic [2:0]    state_r, state_n;
   logic [W-1:0]  a_r, a_n, b_r, b_n, res_r, res_n, disp_r, disp_n;
   logic [CW-1:0] cnt_a_r, cnt_a_n, cnt_b_r, cnt_b_n;
   logic [1:0]    op_r, op_n, pend_r, pend_n;
   logic          chain_r, chain_n, req_r, req_n;
   logic [W-1:0]  digit_ext_s;

   key_event_detect u_key_event_detect (
      .clk      (clk),
      .reset_n  (reset_n),
      .tecla    (tecla),
      .ready    (ready),
      .key_evt  (key_evt_s),
      .key_code (key_code_s)
   );

   assign digit_ext_s = {{(W-4){1'b0}}, key_code_s};

   // Next-state logic: key events, ALU handshake and operand assembly
   always_comb begin
      state_n = state_r;
      a_n     = a_r;
      b_n     = b_r;
      res_n   = res_r;
      cnt_a_n = cnt_a_r;
      cnt_b_n = cnt_b_r;
      op_n    = op_r;
      pend_n  = pend_r;
      chain_n = chain_r;
      req_n   = req_r;
      if (key_evt_s && (key_code_s == KEY_CLR)) begin
         // Clear wins in every state, including over a coincident calc_ack
         state_n = ST_ENTER_A;
         a_n     = '0;
         b_n     = '0;
         res_n   = '0;
         cnt_a_n = '0;
         cnt_b_n = '0;
         op_n    = 2'b00;
         pend_n  = 2'b00;
         chain_n = 1'b0;
         req_n   = 1'b0;
      end else begin
         case (state_r)
            ST_ENTER_A: begin
               if (key_evt_s && is_digit(key_code_s)) begin
                  if (cnt_a_r < CNT_MAX) begin
                     a_n     = {a_r[W-5:0], key_code_s};
                     cnt_a_n = cnt_a_r + CNT_ONE;
                  end else begin
                     a_n = a_r;
                  end
               end else if (key_evt_s && is_op(key_code_s)) begin
                  op_n    = key_to_op(key_code_s);
                  state_n = ST_OP_WAIT;
               end else begin
                  state_n = state_r;
               end
            end
            ST_OP_WAIT: begin
               if (key_evt_s && is_digit(key_code_s)) begin
                  b_n     = digit_ext_s;
                  cnt_b_n = CNT_ONE;
                  state_n = ST_ENTER_B;
               end else if (key_evt_s && is_op(key_code_s)) begin
                  op_n = key_to_op(key_code_s);
               end else begin
                  state_n = state_r;
               end
            end
            ST_ENTER_B: begin
               if (key_evt_s && is_digit(key_code_s)) begin
                  if (cnt_b_r < CNT_MAX) begin
                     b_n     = {b_r[W-5:0], key_code_s};
                     cnt_b_n = cnt_b_r + CNT_ONE;
                  end else begin
                     b_n = b_r;
                  end
               end else if (key_evt_s && (key_code_s == KEY_EQ)) begin
                  chain_n = 1'b0;
                  req_n   = 1'b1;
                  state_n = ST_REQ;
               end else if (key_evt_s && is_op(key_code_s)) begin
                  // Operator after B: compute now, apply this operator to the result
                  pend_n  = key_to_op(key_code_s);
                  chain_n = 1'b1;
                  req_n   = 1'b1;
                  state_n = ST_REQ;
               end else begin
                  state_n = state_r;
               end
            end
            ST_REQ: begin
               if (calc_ack) begin
                  res_n = calc_result;
                  req_n = 1'b0;
                  if (chain_r) begin
                     a_n     = calc_result;
                     cnt_a_n = CNT_MAX;
                     op_n    = pend_r;
                     chain_n = 1'b0;
                     state_n = ST_OP_WAIT;
                  end else begin
                     state_n = ST_RESULT;
                  end
               end else begin
                  req_n = 1'b1;
               end
            end
            ST_RESULT: begin
               if (key_evt_s && is_digit(key_code_s)) begin
                  a_n     = digit_ext_s;
                  cnt_a_n = CNT_ONE;
                  b_n     = '0;
                  cnt_b_n = '0;
                  state_n = ST_ENTER_A;
               end else if (key_evt_s && is_op(key_code_s)) begin
                  a_n     = res_r;
                  cnt_a_n = CNT_MAX;
                  op_n    = key_to_op(key_code_s);
                  state_n = ST_OP_WAIT;
               end else if (key_evt_s && (key_code_s == KEY_EQ)) begin
                  // Repeat the last operation on the result with the same B
                  a_n     = res_r;
                  cnt_a_n = CNT_MAX;
                  chain_n = 1'b0;
                  req_n   = 1'b1;
                  state_n = ST_REQ;
               end else begin
                  state_n = state_r;
               end
            end
            default: begin
               state_n = ST_ENTER_A;
               req_n   = 1'b0;
            end
         endcase
      end
   end

   // Display source follows the state being entered so it updates with it
   always_comb begin
      case (state_n)
         ST_ENTER_A, ST_OP_WAIT: disp_n = a_n;
         ST_ENTER_B, ST_REQ:     disp_n = b_n;
         ST_RESULT:              disp_n = res_n;
         default:                disp_n = '0;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_ENTER_A;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         disp_r  <= '0;
         cnt_a_r <= '0;
         cnt_b_r <= '0;
         op_r    <= 2'b00;
         pend_r  <= 2'b00;
         chain_r <= 1'b0;
         req_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         a_r     <= a_n;
         b_r     <= b_n;
         res_r   <= res_n;
         disp_r  <= disp_n;
         cnt_a_r <= cnt_a_n;
         cnt_b_r <= cnt_b_n;
         op_r    <= op_n;
         pend_r  <= pend_n;
         chain_r <= chain_n;
         req_r   <= req_n;
      end
   end

   assign operand_a  = a_r;
   assign operand_b  = b_r;
   assign op_code    = op_r;
   assign calc_req   = req_r;
   assign disp_value = disp_r;
   assign state_o    = state_r;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_key_sequencer
// Scoreboard bench: each stimulus step queues the output snapshot it should
// produce; a monitor compares every observed change of the output bundle
// against the head of the queue. An output change with nothing queued, or a
// queue not drained on time, is reported as a failure.
// Snapshot layout: {operand_a, operand_b, op_code, calc_req, disp_value, state_o}
// ---------------------------------------------------------------------------
module tb_calc_key_sequencer;

   logic        clk;
   logic        reset_n;
   logic [3:0]  tecla;
   logic        ready;
   logic        calc_ack;
   logic [15:0] calc_result;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic [1:0]  op_code;
   logic        calc_req;
   logic [15:0] disp_value;
   logic [2:0]  state_o;

   typedef struct {
      string       name;
      logic [53:0] v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   calc_key_sequencer #(.NDIG(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tecla       (tecla),
      .ready       (ready),
      .calc_ack    (calc_ack),
      .calc_result (calc_result),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .op_code     (op_code),
      .calc_req    (calc_req),
      .disp_value  (disp_value),
      .state_o     (state_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [53:0] snap();
      return {operand_a, operand_b, op_code, calc_req, disp_value, state_o};
   endfunction

   function automatic void expect_out(input string n, input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] op, input logic req,
                                      input logic [15:0] d, input logic [2:0] st);
      exp_t e;
      e.name = n;
      e.v    = {a, b, op, req, d, st};
      q.push_back(e);
   endfunction

   task automatic drained(input string n);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drained_%s pending=%0d required=0 head=%s", n, q.size(), q[0].name);
      end
   endtask

   task automatic press(input logic [3:0] k, input int hold, input string n);
      @(negedge clk);
      tecla = k;
      ready = 1'b1;
      repeat (hold) @(negedge clk);
      ready = 1'b0;
      repeat (5) @(negedge clk);
      drained(n);
   endtask

   task automatic ack(input logic [15:0] r, input string n);
      @(negedge clk);
      calc_result = r;
      calc_ack    = 1'b1;
      @(negedge clk);
      calc_ack    = 1'b0;
      @(negedge clk);
      drained(n);
   endtask

   // Monitor: compare every change of the output bundle with the scoreboard
   initial begin
      logic [53:0] prev;
      logic [53:0] cur;
      exp_t        e;
      prev = '0;
      forever begin
         @(negedge clk or negedge reset_n);
         #1;
         cur = snap();
         if (mon_en && (cur !== prev)) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_update actual=%h required=no_change", cur);
            end else begin
               e = q.pop_front();
               if (cur !== e.v) begin
                  errors++;
                  $display("FAIL %s actual=%h required=%h", e.name, cur, e.v);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      reset_n     = 1'b1;
      tecla       = 4'h0;
      ready       = 1'b0;
      calc_ack    = 1'b0;
      calc_result = 16'h0000;
      #1 reset_n  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (snap() !== 54'd0) begin
         errors++;
         $display("FAIL reset_state actual=%h required=0", snap());
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;

      // Digit entry, one update per press
      expect_out("dig1", 16'h0001, 16'h0, 2'b00, 1'b0, 16'h0001, 3'd0);
      press(4'h1, 5, "p1");
      expect_out("dig2", 16'h0012, 16'h0, 2'b00, 1'b0, 16'h0012, 3'd0);
      press(4'h2, 5, "p2");
      expect_out("dig3", 16'h0123, 16'h0, 2'b00, 1'b0, 16'h0123, 3'd0);
      press(4'h3, 5, "p3");
      // Long hold shifts exactly once
      expect_out("hold4", 16'h1234, 16'h0, 2'b00, 1'b0, 16'h1234, 3'd0);
      press(4'h4, 200, "hold");
      // Fifth digit ignored once A is full
      press(4'h5, 5, "sat5");
      expect_out("clr1", 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 3'd0);
      press(4'hF, 5, "clr1");

      // Five digits 1..5 into an empty A
      expect_out("f1", 16'h0001, 16'h0, 2'b00, 1'b0, 16'h0001, 3'd0);
      press(4'h1, 5, "f1");
      expect_out("f2", 16'h0012, 16'h0, 2'b00, 1'b0, 16'h0012, 3'd0);
      press(4'h2, 5, "f2");
      expect_out("f3", 16'h0123, 16'h0, 2'b00, 1'b0, 16'h0123, 3'd0);
      press(4'h3, 5, "f3");
      expect_out("f4", 16'h1234, 16'h0, 2'b00, 1'b0, 16'h1234, 3'd0);
      press(4'h4, 5, "f4");
      press(4'h5, 5, "f5");
      expect_out("clr2", 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 3'd0);
      press(4'hF, 5, "clr2");

      // 7 + 5 =, ack after 10 clocks
      expect_out("a7", 16'h0007, 16'h0, 2'b00, 1'b0, 16'h0007, 3'd0);
      press(4'h7, 5, "a7");
      expect_out("add", 16'h0007, 16'h0, 2'b00, 1'b0, 16'h0007, 3'd1);
      press(4'hA, 5, "add");
      expect_out("b5", 16'h0007, 16'h0005, 2'b00, 1'b0, 16'h0005, 3'd2);
      press(4'h5, 5, "b5");
      expect_out("eq_req", 16'h0007, 16'h0005, 2'b00, 1'b1, 16'h0005, 3'd3);
      press(4'hE, 5, "eq");
      repeat (10) @(negedge clk);
      expect_out("ack_res", 16'h0007, 16'h0005, 2'b00, 1'b0, 16'h0012, 3'd4);
      ack(16'h0012, "ack1");

      // Repeat = on the result
      expect_out("rep_req", 16'h0012, 16'h0005, 2'b00, 1'b1, 16'h0005, 3'd3);
      press(4'hE, 5, "rep");
      expect_out("rep_res", 16'h0012, 16'h0005, 2'b00, 1'b0, 16'h0017, 3'd4);
      ack(16'h0017, "ack2");

      // Operator on result, then chained operator
      expect_out("res_sub", 16'h0017, 16'h0005, 2'b01, 1'b0, 16'h0017, 3'd1);
      press(4'hB, 5, "sub");
      expect_out("b3", 16'h0017, 16'h0003, 2'b01, 1'b0, 16'h0003, 3'd2);
      press(4'h3, 5, "b3");
      expect_out("chain_req", 16'h0017, 16'h0003, 2'b01, 1'b1, 16'h0003, 3'd3);
      press(4'hC, 5, "chain");
      expect_out("chain_ack", 16'h0014, 16'h0003, 2'b10, 1'b0, 16'h0014, 3'd1);
      ack(16'h0014, "ack3");
      expect_out("clr3", 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 3'd0);
      press(4'hF, 5, "clr3");

      // calc_ack outside REQ has no effect
      ack(16'h0777, "stray_ack");

      // Clear and ack in the same cycle while in REQ
      expect_out("a9", 16'h0009, 16'h0, 2'b00, 1'b0, 16'h0009, 3'd0);
      press(4'h9, 5, "a9");
      expect_out("div", 16'h0009, 16'h0, 2'b11, 1'b0, 16'h0009, 3'd1);
      press(4'hD, 5, "div");
      expect_out("b2", 16'h0009, 16'h0002, 2'b11, 1'b0, 16'h0002, 3'd2);
      press(4'h2, 5, "b2");
      expect_out("req2", 16'h0009, 16'h0002, 2'b11, 1'b1, 16'h0002, 3'd3);
      press(4'hE, 5, "req2");
      expect_out("clr_ack", 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 3'd0);
      @(negedge clk);
      tecla = 4'hF;
      ready = 1'b1;
      @(negedge clk);
      calc_result = 16'h0099;
      calc_ack    = 1'b1;
      @(negedge clk);
      calc_ack    = 1'b0;
      repeat (3) @(negedge clk);
      ready = 1'b0;
      repeat (5) @(negedge clk);
      drained("clr_ack");

      // Asynchronous reset in ENTER_B
      expect_out("r_a6", 16'h0006, 16'h0, 2'b00, 1'b0, 16'h0006, 3'd0);
      press(4'h6, 5, "r_a6");
      expect_out("r_add", 16'h0006, 16'h0, 2'b00, 1'b0, 16'h0006, 3'd1);
      press(4'hA, 5, "r_add");
      expect_out("r_b8", 16'h0006, 16'h0008, 2'b00, 1'b0, 16'h0008, 3'd2);
      press(4'h8, 5, "r_b8");
      expect_out("async_rst", 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 3'd0);
      @(posedge clk);
      #5 reset_n = 1'b0;
      #2 drained("async_rst");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      expect_out("post_rst", 16'h0007, 16'h0, 2'b00, 1'b0, 16'h0007, 3'd0);
      press(4'h7, 5, "post_rst");

      repeat (5) @(negedge clk);
      drained("final");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
